// File: rtl/traffic_light_controller_timed_if.sv
// Sensor/lamp bundle between the road-side equipment and the intersection controller.
// There is no handshake on this bundle: x and emerg are free-running level inputs sampled
// on every rising clock edge, and hwy/cntry/phase are registered status outputs that are
// valid in every cycle (there is no valid or ready qualifier in either direction).
interface traffic_light_controller_timed_if;
    logic       x;      // country-road car sensor
    logic       emerg;  // emergency preempt, highway priority
    logic [1:0] hwy;    // highway lamp: RED=0, YELLOW=1, GREEN=2
    logic [1:0] cntry;  // country lamp: RED=0, YELLOW=1, GREEN=2
    logic [2:0] phase;  // current controller state

    // Sensor / supervisor side
    modport master (
        output x,
        output emerg,
        input  hwy,
        input  cntry,
        input  phase
    );

    // Controller side
    modport slave (
        input  x,
        input  emerg,
        output hwy,
        output cntry,
        output phase
    );
endinterface

// File: rtl/traffic_light_controller_timed.sv
// Highway/country intersection controller with phase timers, min/max green limits,
// a latched country-road request, all-red clearance and emergency preemption.
// The state register is exported on phase; lamps are registered alongside the state so
// no input reaches an output without passing through a flop.
module traffic_light_controller_timed #(
    parameter int TIMER_W         = 8,
    parameter int MIN_HWY_GREEN   = 16,
    parameter int YELLOW_CYCLES   = 4,
    parameter int ALLRED_CYCLES   = 2,
    parameter int MIN_CNTRY_GREEN = 4,
    parameter int MAX_CNTRY_GREEN = 32
) (
    input  logic                          clk,
    input  logic                          clear,
    traffic_light_controller_timed_if.slave bus
);

    typedef enum logic [2:0] {
        S0 = 3'd0,  // highway green, country red
        S1 = 3'd1,  // highway yellow, country red
        S2 = 3'd2,  // all red before country green
        S3 = 3'd3,  // highway red, country green
        S4 = 3'd4,  // highway red, country yellow
        S5 = 3'd5   // all red before highway green
    } state_t;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;

    // Last timer value of each timed interval (timer is 0 in the first cycle of a state).
    localparam logic [TIMER_W-1:0] HWY_LAST   = TIMER_W'(MIN_HWY_GREEN - 1);
    localparam logic [TIMER_W-1:0] YEL_LAST   = TIMER_W'(YELLOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] AR_LAST    = TIMER_W'(ALLRED_CYCLES - 1);
    localparam logic [TIMER_W-1:0] CMIN_LAST  = TIMER_W'(MIN_CNTRY_GREEN - 1);
    localparam logic [TIMER_W-1:0] CMAX_LAST  = TIMER_W'(MAX_CNTRY_GREEN - 1);

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               req_q,   req_d;
    logic [1:0]         hwy_q,   hwy_d;
    logic [1:0]         cntry_q, cntry_d;

    // Next state, request latch, phase timer and next lamp values.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        timer_d = timer_q;
        hwy_d   = RED;
        cntry_d = RED;

        case (state_q)
            S0: begin
                // A car seen on any edge in S0 is remembered, even on the leaving edge.
                if (bus.x) begin
                    req_d = 1'b1;
                end
                if ((req_q || bus.x) && (timer_q == HWY_LAST) && !bus.emerg) begin
                    state_d = S1;
                end
            end
            S1: begin
                if (timer_q == YEL_LAST) begin
                    state_d = S2;
                end
            end
            S2: begin
                // At the end of clearance an emergency sends control straight back to
                // the highway side instead of granting the country road.
                if (timer_q == AR_LAST) begin
                    state_d = bus.emerg ? S5 : S3;
                end
            end
            S3: begin
                if (bus.emerg || (timer_q == CMAX_LAST) ||
                    (!bus.x && (timer_q >= CMIN_LAST))) begin
                    state_d = S4;
                end
            end
            S4: begin
                // Yellow always runs its full length, emergency or not.
                if (timer_q == YEL_LAST) begin
                    state_d = S5;
                end
            end
            S5: begin
                if (timer_q == AR_LAST) begin
                    state_d = S0;
                end
            end
            default: begin
                // Unused encodings recover through highway yellow, the safe direction.
                state_d = S1;
            end
        endcase

        // The request has been served once the country road turns green.
        if ((state_q == S2) && (state_d == S3)) begin
            req_d = 1'b0;
        end

        // Timer restarts on every state change; in S0 it parks at the min-green mark.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if ((state_q == S0) && (timer_q == HWY_LAST)) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        // Lamps follow the state being entered so they change on the same edge.
        case (state_d)
            S0:      begin hwy_d = GREEN;  cntry_d = RED;    end
            S1:      begin hwy_d = YELLOW; cntry_d = RED;    end
            S3:      begin hwy_d = RED;    cntry_d = GREEN;  end
            S4:      begin hwy_d = RED;    cntry_d = YELLOW; end
            default: begin hwy_d = RED;    cntry_d = RED;    end
        endcase
    end

    // Controller state register with asynchronous clear to highway green.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= S0;
            timer_q <= '0;
            req_q   <= 1'b0;
            hwy_q   <= GREEN;
            cntry_q <= RED;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            req_q   <= req_d;
            hwy_q   <= hwy_d;
            cntry_q <= cntry_d;
        end
    end

    assign bus.hwy   = hwy_q;
    assign bus.cntry = cntry_q;
    assign bus.phase = state_q;

endmodule
